// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART core.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned START_HALF = 7;
    // Wide enough to count a two-stop-bit period (2*OVERSAMPLE ticks).
    localparam int unsigned TICK_W     = 5;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO; write-when-full allowed only alongside a read.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_param.sv
// Full-duplex UART: baud tick generator, TX/RX FIFOs, TX/RX shift engines with
// runtime parity/stop selection, per-word error flags and sticky overrun.
module uart_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIVSR_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIVSR_WIDTH-1:0] baud_final_value,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    input  logic                   two_stop,
    input  logic [DATA_BITS-1:0]   tx_fifo_dataIn,
    input  logic                   tx_fifo_writeEn,
    output logic                   tx_fifo_Full,
    output logic                   tx_busy,
    output logic                   tx,
    input  logic                   rx,
    input  logic                   rx_fifo_readEn,
    output logic [DATA_BITS-1:0]   rx_fifo_dataOut,
    output logic                   rx_perr,
    output logic                   rx_ferr,
    output logic                   rx_fifo_Empty,
    output logic                   rx_overrun,
    input  logic                   rx_overrun_clr
);

    localparam int unsigned       BIT_W      = $clog2(DATA_BITS);
    localparam int unsigned       RXW        = DATA_BITS + 2;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST2 = TICK_W'(2 * OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] START_LAST = TICK_W'(START_HALF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);

    // ---------------- baud tick ----------------
    logic [DIVSR_WIDTH-1:0] baud_cnt;
    logic                   tick;

    // Compare with >= so lowering the divisor below the running count recovers at once.
    assign tick = (baud_cnt >= baud_final_value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + DIVSR_WIDTH'(1);
        end
    end

    // ---------------- TX path ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [TICK_W-1:0]    tx_tick, tx_tick_n;
    logic [BIT_W-1:0]     tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_pen, tx_pen_n;
    logic                 tx_two, tx_two_n;
    logic                 tx_n, tx_busy_n;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wdata (tx_fifo_dataIn),
        .wr    (tx_fifo_writeEn),
        .rd    (tx_pop),
        .rdata (tx_head),
        .full  (tx_fifo_Full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_two   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_pen   <= tx_pen_n;
            tx_two   <= tx_two_n;
            tx       <= tx_n;
            tx_busy  <= tx_busy_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pen_n   = tx_pen;
        tx_two_n   = tx_two;
        tx_pop     = 1'b0;
        tx_n       = 1'b1;
        tx_busy_n  = 1'b0;

        case (tx_state)
            TX_IDLE: tx_pop = !tx_empty;
            TX_START: begin
                if (tick) begin
                    if (tx_tick == TICK_LAST) begin
                        tx_state_n = TX_DATA;
                        tx_tick_n  = '0;
                        tx_bit_n   = '0;
                    end else begin
                        tx_tick_n = tx_tick + TICK_W'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tick == TICK_LAST) begin
                        tx_tick_n  = '0;
                        tx_shift_n = tx_shift >> 1;
                        if (tx_bit == BIT_LAST) begin
                            tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_bit_n = tx_bit + BIT_W'(1);
                        end
                    end else begin
                        tx_tick_n = tx_tick + TICK_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    if (tx_tick == TICK_LAST) begin
                        tx_state_n = TX_STOP;
                        tx_tick_n  = '0;
                    end else begin
                        tx_tick_n = tx_tick + TICK_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tick == (tx_two ? TICK_LAST2 : TICK_LAST)) begin
                        tx_state_n = TX_IDLE;
                        tx_tick_n  = '0;
                        tx_pop     = !tx_empty;
                    end else begin
                        tx_tick_n = tx_tick + TICK_W'(1);
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        // Frame start: capture word and line settings so mid-frame changes are ignored.
        if (tx_pop) begin
            tx_state_n = TX_START;
            tx_tick_n  = '0;
            tx_shift_n = tx_head;
            tx_par_n   = (^tx_head) ^ parity_odd;
            tx_pen_n   = parity_en;
            tx_two_n   = two_stop;
        end

        case (tx_state_n)
            TX_START:  tx_n = 1'b0;
            TX_DATA:   tx_n = tx_shift_n[0];
            TX_PARITY: tx_n = tx_par_n;
            default:   tx_n = 1'b1;
        endcase
        tx_busy_n = (tx_state_n != TX_IDLE);
    end

    // ---------------- RX path ----------------
    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state, rx_state_n;
    logic [TICK_W-1:0]    rx_tick, rx_tick_n;
    logic [BIT_W-1:0]     rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_par_err, rx_par_err_n;
    logic                 rx_push;
    logic                 rx_full;
    logic [RXW-1:0]       rx_head;
    logic                 overrun_set;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync    <= 2'b11;
            rx_state   <= RX_IDLE;
            rx_tick    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_err <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[0], rx};
            rx_state   <= rx_state_n;
            rx_tick    <= rx_tick_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_par_err <= rx_par_err_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_tick_n    = rx_tick;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        rx_par_err_n = rx_par_err;
        rx_push      = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_n = RX_START;
                    rx_tick_n  = '0;
                end
            end
            RX_START: begin
                // Re-check near mid start bit; a high line means it was a glitch.
                if (tick) begin
                    if (rx_tick == START_LAST) begin
                        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                        rx_tick_n  = '0;
                        rx_bit_n   = '0;
                    end else begin
                        rx_tick_n = rx_tick + TICK_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tick == TICK_LAST) begin
                        rx_tick_n  = '0;
                        rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_LAST) begin
                            rx_state_n   = parity_en ? RX_PARITY : RX_STOP;
                            rx_par_err_n = 1'b0;
                        end else begin
                            rx_bit_n = rx_bit + BIT_W'(1);
                        end
                    end else begin
                        rx_tick_n = rx_tick + TICK_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    if (rx_tick == TICK_LAST) begin
                        rx_state_n   = RX_STOP;
                        rx_tick_n    = '0;
                        rx_par_err_n = rx_s != ((^rx_shift) ^ parity_odd);
                    end else begin
                        rx_tick_n = rx_tick + TICK_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tick == TICK_LAST) begin
                        rx_state_n = RX_IDLE;
                        rx_tick_n  = '0;
                        rx_push    = 1'b1;
                    end else begin
                        rx_tick_n = rx_tick + TICK_W'(1);
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    uart_fifo #(
        .WIDTH (RXW),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wdata ({!rx_s, rx_par_err, rx_shift}),
        .wr    (rx_push),
        .rd    (rx_fifo_readEn),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_fifo_Empty)
    );

    assign rx_fifo_dataOut = rx_head[DATA_BITS-1:0];
    assign rx_perr         = rx_head[DATA_BITS];
    assign rx_ferr         = rx_head[DATA_BITS+1];

    // A word is lost only when the FIFO is full and not being drained this cycle.
    assign overrun_set = rx_push && rx_full && !rx_fifo_readEn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
        end else if (overrun_set) begin
            rx_overrun <= 1'b1;
        end else if (rx_overrun_clr) begin
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART core: baud tick generator, TX and RX FIFOs, TX and RX shift engines.
- Adds to the current UART:
  - configurable data width and FIFO depth;
  - runtime parity and stop-bit selection;
  - per-word parity and framing error flags;
  - sticky overrun detection;
  - RX input synchroniser.
- Sits behind the APB slave wrapper; all control and status lines are exposed as plain ports.

Parameters:
- DATA_BITS, 8, character width, legal range 5..8; LSB transmitted first.
- FIFO_DEPTH, 16, entries per FIFO; power of two, minimum 2.
- DIVSR_WIDTH, 11, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- baud_final_value  in  DIVSR_WIDTH  tick period = baud_final_value+1 clk cycles; 16 ticks per bit.
- parity_en  in  1  1 = parity bit after data.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0.
- two_stop  in  1  1 = two stop bits, 0 = one.
- tx_fifo_dataIn  in  DATA_BITS  TX write data.
- tx_fifo_writeEn  in  1  TX push strobe.
- tx_fifo_Full  out  1  TX FIFO full.
- tx_busy  out  1  TX engine not idle.
- tx  out  1  serial output; idles high.
- rx  in  1  serial input; asynchronous.
- rx_fifo_readEn  in  1  RX pop strobe.
- rx_fifo_dataOut  out  DATA_BITS  RX head word (first-word-fall-through).
- rx_perr  out  1  parity error flag of the head word.
- rx_ferr  out  1  framing error flag of the head word.
- rx_fifo_Empty  out  1  RX FIFO empty.
- rx_overrun  out  1  sticky; set when a received word is dropped.
- rx_overrun_clr  in  1  clears rx_overrun.

Behaviour:
- Reset (async):
  - tx=1, tx_busy=0.
  - Both FIFOs empty: tx_fifo_Full=0, rx_fifo_Empty=1.
  - rx_fifo_dataOut=0, rx_perr=0, rx_ferr=0, rx_overrun=0.
  - Baud counter=0; both engines in IDLE; synchroniser flops=1.
- Baud generator:
  - Counter runs 0..baud_final_value, then wraps to 0.
  - tick is high for 1 cycle when counter==baud_final_value.
  - baud_final_value=0 gives a tick every cycle.
- FIFO:
  - Write when full is ignored. Read when empty is ignored.
  - Simultaneous read+write when full: both take effect, count unchanged.
  - Simultaneous read+write when empty: write only.
  - Data is visible at the head 1 cycle after the write.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: if the FIFO is not empty, pop the head into the shift register in the same cycle; go to START; tick counter=0.
  - START: tx=0 for 16 ticks.
  - DATA: DATA_BITS bits, LSB first, 16 ticks each.
  - PARITY: only when parity_en; bit = XOR(data) ^ parity_odd; 16 ticks.
  - STOP: tx=1 for 16 ticks, or 32 ticks when two_stop; then IDLE.
  - Back-to-back: a non-empty FIFO at end of STOP starts the next frame with no idle gap.
  - tx_busy = state!=IDLE.
  - parity_en, parity_odd and two_stop are sampled at frame start; changes mid-frame do not affect the current frame.
- RX:
  - rx passes through a 2-flop synchroniser before use.
  - IDLE: a low synchronised rx enters START.
  - START: wait 7 ticks; if the line is high, return to IDLE (glitch rejected); else go to DATA.
  - DATA: sample every 16 ticks; DATA_BITS samples, LSB first.
  - PARITY: sample after 16 ticks; perr = received bit != expected.
  - STOP: sample after 16 ticks; ferr = sampled bit == 0. The second stop bit is not checked; RX returns to IDLE after the first stop sample.
  - Done: push {ferr, perr, data} into the RX FIFO.
  - If the RX FIFO is full and is not popped in the same cycle, the word is dropped and rx_overrun is set.
- rx_overrun:
  - rx_overrun_clr clears it.
  - A set and a clear in the same cycle: set wins.
- Reset mid-frame: tx returns to 1 immediately; the partial frame is lost and the FIFO contents are discarded.

Decomposition:
- Package uart_pkg holds:
  - state enums tx_state_t and rx_state_t;
  - constant OVERSAMPLE=16;
  - constant START_HALF=7.
- Sub-module uart_fifo #(WIDTH, DEPTH), instantiated twice:
  - TX instance: WIDTH=DATA_BITS.
  - RX instance: WIDTH=DATA_BITS+2.
- Baud generator, TX FSM, RX FSM and the overrun flag live inline in uart_param.

Test Plan:
- 8N1, divsr=0, push 0xA5:
  - tx shows 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1.
  - tx_busy falls after 160 cycles.
- Loopback tx→rx, 8E2, push 0x3C and 0xFF back-to-back:
  - RX pops 0x3C then 0xFF with perr=0 and ferr=0.
  - tx shows a 32-tick stop period between the two frames.
- 8O1 transmitter into an even-parity receiver, word 0x01: popped word 0x01 with rx_perr=1.
- Drive an rx frame with stop=0 (word 0x55): popped word 0x55 with rx_ferr=1 and rx_perr=0.
- FIFO_DEPTH=4, receive 5 words without popping:
  - rx_overrun=1; the FIFO holds the first 4 words.
  - rx_overrun_clr clears the flag.
- Assert reset during the DATA state of a TX frame: tx=1 next edge, tx_busy=0, tx_fifo_Full=0, rx_fifo_Empty=1.
